// File: rtl/mar_burst_pkg.sv
// Shared types and defaults for the burst-capable memory address register.
// The two-state controller encoding lives here so every file agrees on it.
package mar_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_BUS_W  = 16;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_STRIDE = 1;

endpackage

// File: rtl/mar_addr_next.sv
// Combinational next-address: bits above the wrap window are held, the low
// WIN_W bits advance by STRIDE modulo 2^WIN_W, so wrapping is silent.
module mar_addr_next #(
  parameter int ADDR_W = 16,
  parameter int WIN_W  = ADDR_W,
  parameter int STRIDE = 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next
);

  localparam logic [WIN_W-1:0] STEP = WIN_W'(STRIDE);

  logic [WIN_W-1:0] low_next;

  assign low_next = addr[WIN_W-1:0] + STEP;

  generate
    if (WIN_W < ADDR_W) begin : g_win
      assign next = {addr[ADDR_W-1:WIN_W], low_next};
    end else begin : g_full
      assign next = low_next;
    end
  endgenerate

endmodule

// File: rtl/mar_burst.sv
// Memory address register with single-step, load and a handshaked burst
// engine; all outputs are registered, next-state logic is purely combinational.
module mar_burst
  import mar_burst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BUS_W  = DEF_BUS_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int WIN_W  = ADDR_W,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mar_write,
  input  logic              len_write,
  input  logic              mar_inc,
  input  logic              burst_start,
  input  logic              abort,
  input  logic [BUS_W-1:0]  bus,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mar_out,
  output logic              mem_req,
  output logic [LEN_W-1:0]  remaining,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] mar_n, addr_inc;
  logic [LEN_W-1:0]  rem_n, eff_len;
  logic              req_n, done_n, xfer;

  mar_addr_next #(
    .ADDR_W (ADDR_W),
    .WIN_W  (WIN_W),
    .STRIDE (STRIDE)
  ) u_addr_next (
    .addr (mar_out),
    .next (addr_inc)
  );

  // A length written alongside burst_start is the length that burst uses.
  assign eff_len = len_write ? bus[LEN_W-1:0] : remaining;
  assign xfer    = mem_req && mem_ack;

  always_comb begin
    state_n = state;
    mar_n   = mar_out;
    rem_n   = remaining;
    req_n   = mem_req;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        req_n = 1'b0;
        if (len_write) rem_n = bus[LEN_W-1:0];
        if (burst_start) begin
          if (eff_len != '0) begin
            state_n = BURST;
            req_n   = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end else if (mar_write) begin
          mar_n = bus[ADDR_W-1:0];
        end else if (mar_inc) begin
          mar_n = addr_inc;
        end
      end
      BURST: begin
        // An ack is honoured even when abort arrives in the same cycle.
        if (xfer) begin
          mar_n = addr_inc;
          rem_n = remaining - LEN_W'(1);
        end
        if (abort || (xfer && remaining == LEN_W'(1))) begin
          state_n = IDLE;
          req_n   = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mar_out   <= '0;
      remaining <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mar_out   <= mar_n;
      remaining <= rem_n;
      mem_req   <= req_n;
      busy      <= (state_n == BURST);
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_mar_burst.sv
// Directed bench for mar_burst: a vector table for the single-cycle behaviour
// plus hand sequences for the stalled handshake and the wrap window.
module tb_mar_burst;

  logic        clk = 1'b0;
  logic        rst, mar_write, len_write, mar_inc, burst_start, abort, mem_ack;
  logic [15:0] bus;
  logic [15:0] mar_out, w_mar_out;
  logic        mem_req, busy, done, w_mem_req, w_busy, w_done;
  logic [7:0]  remaining, w_remaining;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        mw;
    logic        lw;
    logic        mi;
    logic        bs;
    logic        ab;
    logic        ack;
    logic [15:0] bus;
    logic [15:0] mar;
    logic        req;
    logic [7:0]  rem;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mar_burst dut (
    .clk(clk), .rst(rst), .mar_write(mar_write), .len_write(len_write),
    .mar_inc(mar_inc), .burst_start(burst_start), .abort(abort), .bus(bus),
    .mem_ack(mem_ack), .mar_out(mar_out), .mem_req(mem_req),
    .remaining(remaining), .busy(busy), .done(done)
  );

  mar_burst #(.WIN_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .mar_write(mar_write), .len_write(len_write),
    .mar_inc(mar_inc), .burst_start(burst_start), .abort(abort), .bus(bus),
    .mem_ack(mem_ack), .mar_out(w_mar_out), .mem_req(w_mem_req),
    .remaining(w_remaining), .busy(w_busy), .done(w_done)
  );

  function automatic vec_t mk(input logic r, mw, lw, mi, bs, ab, ack,
                              input logic [15:0] b, m, input logic q,
                              input logic [7:0] rm, input logic bz, dn);
    vec_t t;
    t.rst = r; t.mw = mw; t.lw = lw; t.mi = mi; t.bs = bs; t.ab = ab;
    t.ack = ack; t.bus = b; t.mar = m; t.req = q; t.rem = rm;
    t.busy = bz; t.done = dn;
    return t;
  endfunction

  // Drive one cycle of inputs at the falling edge, then step past the rising edge.
  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    rst = t.rst; mar_write = t.mw; len_write = t.lw; mar_inc = t.mi;
    burst_start = t.bs; abort = t.ab; mem_ack = t.ack; bus = t.bus;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int i, input vec_t t);
    checkOutput($sformatf("vec%0d mar_out", i), 32'(mar_out), 32'(t.mar));
    checkOutput($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(t.req));
    checkOutput($sformatf("vec%0d remaining", i), 32'(remaining), 32'(t.rem));
    checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(t.busy));
    checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(t.done));
  endtask

  // Plain input-only cycle for the hand sequences.
  function automatic vec_t cyc(input logic mw, lw, bs, ack, input logic [15:0] b);
    return mk(1'b1, mw, lw, 1'b0, bs, 1'b0, ack, b, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0);
  endfunction

  initial begin
    logic [15:0] exp_mar;
    logic [7:0]  exp_rem;
    logic [15:0] wrap_exp [5];
    int          dones, transfers;
    logic        fin, ack;

    rst = 1'b0; mar_write = 1'b0; len_write = 1'b0; mar_inc = 1'b0;
    burst_start = 1'b0; abort = 1'b0; mem_ack = 1'b0; bus = '0;

    //            r  mw lw mi bs ab ack bus       mar       req rem  busy done
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 16'h0100, 16'h0100, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0101, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0102, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0103, 0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 16'h2000, 16'h2000, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0004, 16'h2000, 0, 8'd4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h2000, 1, 8'd4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h2001, 1, 8'd3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h2002, 1, 8'd2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h2003, 1, 8'd1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h2004, 0, 8'd0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h2004, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h2004, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h2004, 0, 8'd0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h2004, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 16'h0007, 16'h0007, 0, 8'd7, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 16'h0040, 16'h0040, 0, 8'd7, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 16'h0099, 16'h0040, 1, 8'd7, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 16'h0011, 16'h0040, 1, 8'd7, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0040, 0, 8'd7, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 16'h3000, 16'h3000, 0, 8'd7, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0005, 16'h3000, 0, 8'd5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h3000, 1, 8'd5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h3001, 1, 8'd4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h3002, 0, 8'd3, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h3002, 1, 8'd3, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 16'h5555, 16'h3003, 1, 8'd2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h3003, 1, 8'd2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 8'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'd0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
    end

    // Stalled handshake: ack only every third cycle of a 4-transfer burst.
    applyStimulus(cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h2000));
    applyStimulus(cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004));
    applyStimulus(cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000));
    checkOutput("stall start req", 32'(mem_req), 32'd1);
    exp_mar = 16'h2000; exp_rem = 8'd4; dones = 0; transfers = 0; fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      ack = ((k % 3) == 2);
      applyStimulus(cyc(1'b0, 1'b0, 1'b0, ack, 16'h0000));
      if (ack) begin
        exp_mar = exp_mar + 16'd1;
        exp_rem = exp_rem - 8'd1;
        transfers++;
      end
      if (done) dones++;
      checkOutput($sformatf("stall k%0d mar_out", k), 32'(mar_out), 32'(exp_mar));
      checkOutput($sformatf("stall k%0d mem_req", k), 32'(mem_req), 32'(exp_rem != 0));
      checkOutput($sformatf("stall k%0d done", k), 32'(done), 32'(ack && exp_rem == 0));
      if (exp_rem == 0) fin = 1'b1;
    end
    applyStimulus(cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    if (done) dones++;
    checkOutput("stall finished in budget", 32'(fin), 32'd1);
    checkOutput("stall transfers", 32'(transfers), 32'd4);
    checkOutput("stall done count", 32'(dones), 32'd1);
    checkOutput("stall remaining", 32'(remaining), 32'd0);
    checkOutput("stall busy", 32'(busy), 32'd0);

    // Wrap inside a 16-address window on the WIN_W=4 instance.
    wrap_exp[0] = 16'h123E; wrap_exp[1] = 16'h123F; wrap_exp[2] = 16'h1230;
    wrap_exp[3] = 16'h1231; wrap_exp[4] = 16'h1232;
    applyStimulus(cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h123E));
    applyStimulus(cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004));
    applyStimulus(cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000));
    checkOutput("wrap addr0", 32'(w_mar_out), 32'(wrap_exp[0]));
    for (int k = 1; k < 5; k++) begin
      applyStimulus(cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000));
      checkOutput($sformatf("wrap addr%0d", k), 32'(w_mar_out), 32'(wrap_exp[k]));
    end
    checkOutput("wrap done", 32'(w_done), 32'd1);
    checkOutput("wrap remaining", 32'(w_remaining), 32'd0);
    checkOutput("nowrap addr", 32'(mar_out), 32'h1242);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mar_burst.md
MAR_BURST -- requirements
Module: mar_burst

Interface
REQ-001 Parameter ADDR_W, 16, address register width in bits.
REQ-002 Parameter BUS_W, 16, bus width; ADDR_W SHALL be <= BUS_W.
REQ-003 Parameter LEN_W, 8, burst-length counter width.
REQ-004 Parameter WIN_W, ADDR_W, wrap-window width; the address wraps within an aligned 2^WIN_W window, and WIN_W SHALL be <= ADDR_W.
REQ-005 Parameter STRIDE, 1, address increment per accepted transfer, taken mod 2^WIN_W.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-008 mar_write  input  1  load the address register from bus[ADDR_W-1:0].
REQ-009 len_write  input  1  load the length register from bus[LEN_W-1:0].
REQ-010 mar_inc  input  1  single-step the address by STRIDE.
REQ-011 burst_start  input  1  begin a burst of length-register transfers.
REQ-012 abort  input  1  terminate the active burst.
REQ-013 bus  input  BUS_W  shared data bus.
REQ-014 mem_ack  input  1  memory accepts the current request.
REQ-015 mar_out  output  ADDR_W  current address, registered.
REQ-016 mem_req  output  1  request valid, registered.
REQ-017 remaining  output  LEN_W  transfers left in the burst.
REQ-018 busy  output  1  high in state BURST.
REQ-019 done  output  1  one-cycle pulse at burst completion or abort.

Function
REQ-020 The block SHALL have two states, IDLE and BURST, with done as a registered pulse.
REQ-021 Next address: upper bits [ADDR_W-1:WIN_W] are held; lower bits become (lower + STRIDE) mod 2^WIN_W.
REQ-022 IDLE command priority: burst_start > mar_write > mar_inc; each command takes effect on the next edge.
REQ-023 len_write in IDLE SHALL load remaining in the same cycle as any other command.
REQ-024 burst_start with remaining != 0 SHALL move to BURST and assert mem_req on the next cycle.
REQ-025 burst_start with remaining == 0 SHALL stay in IDLE, pulse done on the next cycle, and never assert mem_req.
REQ-026 In BURST, mem_req SHALL be held with mar_out stable until mem_ack; a request is never withdrawn while unacknowledged, except by abort or reset.
REQ-027 On a cycle with mem_req && mem_ack, the next edge SHALL advance mar_out per REQ-021 and decrement remaining by 1.
REQ-028 Back-to-back acks SHALL sustain one transfer per cycle, with no bubble.
REQ-029 The ack of the final transfer (remaining == 1) SHALL return the block to IDLE, drop mem_req, and pulse done on the next cycle; mar_out then points one stride past the last address.
REQ-030 abort in BURST SHALL return to IDLE, drop mem_req, and pulse done.
REQ-031 abort coinciding with mem_ack SHALL still count that transfer: address advances and remaining decrements.
REQ-032 In BURST, mar_write, len_write, mar_inc and burst_start SHALL be ignored.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 Address wrap across the window boundary SHALL occur silently, with no flag.
REQ-035 mem_ack outside BURST SHALL be ignored.

Reset
REQ-036 When rst == 0 at a rising edge, the block SHALL set mar_out=0, remaining=0, mem_req=0, done=0, busy=0, state=IDLE.
REQ-037 Reset mid-burst SHALL abandon the burst without a done pulse; reset overrides all inputs.

Structure
REQ-038 State encoding and the IDLE/BURST localparams SHALL live in the shared SAP package/include file.
REQ-039 The next-address computation (REQ-021) SHALL be a combinational sub-module mar_addr_next(ADDR_W, WIN_W, STRIDE).
REQ-040 Registers SHALL be written only in a clocked block, with next-state logic in a separate combinational block.

Verification
REQ-041 Sequence: mar_write bus=0x0100, then mar_inc x3 -> mar_out=0x0103; then rst=0 for one edge -> all outputs 0.
REQ-042 Burst: len_write=4 at address 0x2000, burst_start, mem_ack held high -> mar_out 0x2000..0x2003 on consecutive cycles, done one cycle after the 4th ack, mar_out=0x2004, remaining=0.
REQ-043 Stalled handshake: same burst with mem_ack high only on every third cycle -> mar_out and mem_req stable between acks, 4 transfers total, single done.
REQ-044 Wrap: WIN_W=4, address 0x123E, len=4 -> addresses 0x123E, 0x123F, 0x1230, 0x1231.
REQ-045 Length zero: burst_start with remaining=0 -> done pulse next cycle, mem_req never high.
REQ-046 Abort: abort together with the 2nd ack of a len=5 burst -> 2 transfers counted, remaining=3, done pulse; then mar_write in the same cycle as the 1st ack of a fresh burst -> write ignored.
